// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for a 4:1 single-bit mux.
// Four requesters share one mux output. One requester is granted at a time,
// Sel follows the grant, and the selected Ent bit is registered onto Sal
// with a Valid qualifier. Every grant is followed by one idle GAP cycle.
//
// Optional feature: define MUX_RR_LOCK_EN to add the Lock input. While Lock
// is high and the granted requester keeps requesting, the hold limit is not
// enforced; the hold counter saturates at HOLD_MAX instead.
//
// Parameter constraints: HOLD_MAX in 1..15, and 2**CNT_W > HOLD_MAX.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic [3:0] Ent,
`ifdef MUX_RR_LOCK_EN
  input  logic       Lock,
`endif
  output logic [3:0] Gnt,
  output logic [1:0] Sel,
  output logic       Sal,
  output logic       Valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             req_sel;
  logic             lock_hold;
  logic             hold_done;
  logic             grant_exit;
  logic             arb_state;
  logic             arb_win;

  // The current owner's request line, and whether a lock keeps it past the limit
  assign req_sel = Req[Sel];

`ifdef MUX_RR_LOCK_EN
  assign lock_hold = Lock & req_sel;
`else
  assign lock_hold = 1'b0;
`endif

  // A grant ends when its owner stops requesting or its hold budget is used up;
  // both at once is still one exit.
  assign hold_done  = (cnt == HOLD_LIM) && !lock_hold;
  assign grant_exit = (state == ST_GRANT) && (!req_sel || hold_done);

  // IDLE and GAP arbitrate identically; only GRANT is excluded
  assign arb_state = (state == ST_IDLE) || (state == ST_GAP);
  assign arb_win   = arb_state && win_found;

  // Rotating priority scan: start at ptr, ascend, wrap 3->0, first request wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && Req[ptr + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 2'(k);
      end
    end
  end

  // Next-state selection for the IDLE / GRANT / GAP sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = win_found ? ST_GRANT : ST_IDLE;
      ST_GAP:   state_nxt = win_found ? ST_GRANT : ST_IDLE;
      ST_GRANT: state_nxt = grant_exit ? ST_GAP : ST_GRANT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and select: load on an arbitration win, clear Gnt on exit, Sel holds
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Gnt <= 4'b0000;
      Sel <= 2'b00;
    end else if (arb_win) begin
      Gnt <= 4'b0001 << win_idx;
      Sel <= win_idx;
    end else if (grant_exit) begin
      Gnt <= 4'b0000;
    end
  end

  // Hold counter: counts GRANT cycles of the current owner, saturating at the limit
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= CNT_ZERO;
    end else if (arb_win) begin
      cnt <= CNT_ONE;
    end else if (grant_exit) begin
      cnt <= CNT_ZERO;
    end else if (state == ST_GRANT && cnt != HOLD_LIM) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Priority pointer: the requester after the one just served goes first next time
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ptr <= 2'b00;
    end else if (grant_exit) begin
      ptr <= Sel + 2'd1;
    end
  end

  // Output data path: sample the granted requester's bit during every GRANT cycle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Sal   <= 1'b0;
      Valid <= 1'b0;
    end else if (state == ST_GRANT) begin
      Sal   <= Ent[Sel];
      Valid <= 1'b1;
    end else begin
      Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for mux_rr_arbiter.
// A transaction-level reference model predicts the outputs after each clock
// edge and pushes them into queues; a monitor on the falling edge pops and
// compares. Directed sequences cover single requester, rotation, wrap and
// simultaneous drop/expiry; a randomized phase and an async reset follow.
module tb_mux_rr_arbiter;

  localparam int HOLD = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Req = 4'b0000;
  logic [3:0] Ent = 4'b0000;
`ifdef MUX_RR_LOCK_EN
  logic       Lock = 1'b0;
`endif
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic       Sal;
  logic       Valid;

  mux_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Req   (Req),
    .Ent   (Ent),
`ifdef MUX_RR_LOCK_EN
    .Lock  (Lock),
`endif
    .Gnt   (Gnt),
    .Sel   (Sel),
    .Sal   (Sal),
    .Valid (Valid)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sal;
    logic       valid;
  } obs_t;

  obs_t ctlQ[$];
  logic dataQ[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: who owns the mux, how long they have had it, who is next
  int mOwner = -1;
  int mSel   = 0;
  int mNext  = 0;
  int mHeld  = 0;
  bit mSal   = 1'b0;
  bit mValid = 1'b0;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic resetModel();
    mOwner = -1;
    mSel   = 0;
    mNext  = 0;
    mHeld  = 0;
    mSal   = 1'b0;
    mValid = 1'b0;
  endtask

  task automatic stepModel(input logic [3:0] req, input logic [3:0] ent);
    obs_t e;
    if (mOwner >= 0) begin
      mSal   = ent[mOwner];
      mValid = 1'b1;
      dataQ.push_back(ent[mOwner]);
      if (!req[mOwner] || mHeld >= HOLD) begin
        mNext  = (mOwner + 1) % 4;
        mOwner = -1;
        mHeld  = 0;
      end else begin
        mHeld++;
      end
    end else begin
      mValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (mNext + k) % 4;
        if (mOwner < 0 && req[i]) begin
          mOwner = i;
          mSel   = i;
          mHeld  = 1;
        end
      end
    end
    e.gnt   = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
    e.sel   = 2'(mSel);
    e.sal   = mSal;
    e.valid = mValid;
    ctlQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] ent);
    Req = req;
    Ent = ent;
    @(posedge Clk);
    stepModel(req, ent);
    @(negedge Clk);
  endtask

  // Monitor: every predicted cycle is compared, and each Valid beat consumes one data item
  always @(negedge Clk) begin
    obs_t e;
    if (ctlQ.size() > 0) begin
      e = ctlQ.pop_front();
      checkOutput("cycle{gnt,sel,sal,valid}", {Gnt, Sel, Sal, Valid}, e);
      if (Valid === 1'b1) begin
        if (dataQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL data at %0t: Valid=1 with Sal=%b, expected no valid beat", $time, Sal);
        end else begin
          checkOutput("data_sal", {7'b0, Sal}, {7'b0, dataQ.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    resetModel();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    checkOutput("reset_values", {Gnt, Sel, Sal, Valid}, 8'h00);

    $display("[TB] single requester");
    repeat (3) applyStimulus(4'b0010, 4'b0010);
    applyStimulus(4'b0000, 4'b0010);
    repeat (2) applyStimulus(4'b0000, 4'b0000);

    $display("[TB] wrap from pointer 2 to requester 0");
    repeat (2) applyStimulus(4'b0001, 4'(($urandom)));
    repeat (2) applyStimulus(4'b0000, 4'(($urandom)));

    $display("[TB] rotation with all requesting");
    applyStimulus(4'b1000, 4'b1000);
    applyStimulus(4'b0000, 4'b0000);
    repeat (4 * (HOLD + 1) + 2) applyStimulus(4'b1111, 4'(($urandom)));
    repeat (2) applyStimulus(4'b0000, 4'b0000);

    $display("[TB] wrap after requester 3");
    applyStimulus(4'b1000, 4'b1000);
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) applyStimulus(4'b1010, 4'(($urandom)));
    repeat (2) applyStimulus(4'b0000, 4'b0000);

    $display("[TB] drop and hold expiry together");
    applyStimulus(4'b1000, 4'b1000);
    applyStimulus(4'b0000, 4'b0000);
    repeat (3) applyStimulus(4'b0011, 4'b0001);
    repeat (2) applyStimulus(4'b0010, 4'b0010);
    repeat (2) applyStimulus(4'b0000, 4'b0000);

    $display("[TB] randomized traffic");
    rq = 4'b0000;
    for (int n = 0; n < 500; n++) begin
      rq = rq ^ 4'($urandom & $urandom);
      applyStimulus(rq, 4'($urandom));
    end
    repeat (2) applyStimulus(4'b0000, 4'b0000);

    $display("[TB] asynchronous reset mid-grant");
    repeat (2) applyStimulus(4'b0100, 4'b0100);
    #2;
    Rst = 1'b1;
    Req = 4'b0000;
    #1;
    checkOutput("reset_async", {Gnt, Sel, Sal, Valid}, 8'h00);
    resetModel();
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) applyStimulus(4'b0000, 4'($urandom));

    rq = 4'b0000;
    for (int n = 0; n < 60; n++) begin
      rq = rq ^ 4'($urandom & $urandom);
      applyStimulus(rq, 4'($urandom));
    end

    @(negedge Clk);
    #1;
    checkOutput("queues_drained", 8'(ctlQ.size() + dataQ.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
